// File: rtl/keypad_pkg.sv
// Shared types and key map for the 4x4 keypad emulator and its scanner bench.
// Build option KEYPAD_EMU_QUEUE_EN (used by keypad_emulator) adds a request FIFO.
package keypad_pkg;

    typedef enum logic [1:0] {IDLE, PRESS, RELEASE} state_e;

    localparam logic [3:0] COL0 = 4'b1000;
    localparam logic [3:0] COL1 = 4'b0100;
    localparam logic [3:0] COL2 = 4'b0010;
    localparam logic [3:0] COL3 = 4'b0001;

    localparam logic [3:0] ROW0 = 4'b1000;
    localparam logic [3:0] ROW1 = 4'b0100;
    localparam logic [3:0] ROW2 = 4'b0010;
    localparam logic [3:0] ROW3 = 4'b0001;

    typedef struct packed {
        logic [3:0] col;
        logic [3:0] row;
    } colrow_t;

    // Scanner code map: which column strobe and row line represent each key.
    function automatic colrow_t key_to_colrow(input logic [3:0] code);
        colrow_t cr;
        case (code)
            4'd1:    cr = '{col: COL0, row: ROW0};
            4'd4:    cr = '{col: COL0, row: ROW1};
            4'd7:    cr = '{col: COL0, row: ROW2};
            4'd14:   cr = '{col: COL0, row: ROW3};
            4'd2:    cr = '{col: COL1, row: ROW0};
            4'd5:    cr = '{col: COL1, row: ROW1};
            4'd8:    cr = '{col: COL1, row: ROW2};
            4'd0:    cr = '{col: COL1, row: ROW3};
            4'd3:    cr = '{col: COL2, row: ROW0};
            4'd6:    cr = '{col: COL2, row: ROW1};
            4'd9:    cr = '{col: COL2, row: ROW2};
            4'd15:   cr = '{col: COL2, row: ROW3};
            4'd10:   cr = '{col: COL3, row: ROW0};
            4'd11:   cr = '{col: COL3, row: ROW1};
            4'd12:   cr = '{col: COL3, row: ROW2};
            default: cr = '{col: COL3, row: ROW3};
        endcase
        return cr;
    endfunction

endpackage

// File: rtl/key_fifo.sv
// 4-entry request FIFO for keypad_emulator; only compiled when KEYPAD_EMU_QUEUE_EN is defined.
`ifdef KEYPAD_EMU_QUEUE_EN
module key_fifo
    import keypad_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic [W-1:0] din_i,
    input  logic         pop_i,
    output logic [W-1:0] dout_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int DEPTH = 4;

    logic [DEPTH-1:0][W-1:0] mem_q;
    logic [1:0]              wp_q, rp_q;
    logic [2:0]              cnt_q;
    logic                    do_push, do_pop;

    assign empty_o = (cnt_q == 3'd0);
    assign full_o  = (cnt_q == 3'd4);
    assign dout_o  = mem_q[rp_q];
    assign do_pop  = pop_i && !empty_o;
    // A pop in the same cycle frees the slot, so a full FIFO may still take a push.
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q <= '0;
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wp_q] <= din_i;
                wp_q        <= wp_q + 2'd1;
            end
            if (do_pop) rp_q <= rp_q + 2'd1;
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 3'd1;
                2'b01:   cnt_q <= cnt_q - 3'd1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule
`endif

// File: rtl/keypad_emulator.sv
// Far-end 4x4 keypad model: answers column strobes on the row lines for a requested key.
// KEYPAD_EMU_QUEUE_EN defined puts a 4-deep request FIFO in front of the state machine.
module keypad_emulator
    import keypad_pkg::*;
#(
    parameter int HOLD_SCANS = 2,
    parameter int GAP_SCANS  = 2,
    parameter int CNT_W      = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] c,
    output logic [3:0] r,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic       key_ready,
    output logic       busy,
    output logic       done
);

    localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'((HOLD_SCANS == 0) ? 1 : HOLD_SCANS);
    localparam logic [CNT_W-1:0] GAP_LIM  = CNT_W'(GAP_SCANS);

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_inc;
    logic [3:0]       tcol_q, trow_q;
    logic             done_q;

    logic             req_vld;
    logic [3:0]       req_code;
    logic             req_take;
    colrow_t          req_cr;

`ifdef KEYPAD_EMU_QUEUE_EN
    logic       fifo_full, fifo_empty;
    logic [3:0] fifo_head;

    key_fifo #(.W(4)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (key_valid && !fifo_full),
        .din_i   (key_code),
        .pop_i   (req_take),
        .dout_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign key_ready = rst_n && !fifo_full;
    assign req_vld   = !fifo_empty;
    assign req_code  = fifo_head;
`else
    assign key_ready = rst_n && (state_q == IDLE);
    assign req_vld   = key_valid;
    assign req_code  = key_code;
`endif

    assign req_take = (state_q == IDLE) && req_vld;
    assign req_cr   = key_to_colrow(req_code);
    assign cnt_inc  = cnt_q + CNT_W'(1);

    // tcol_q is one-hot, so a zero or multi-bit strobe never matches and never counts.
    assign r    = (state_q == PRESS && c == tcol_q) ? trow_q : 4'b0000;
    assign busy = (state_q != IDLE);
    assign done = done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            tcol_q  <= '0;
            trow_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_take) begin
                        tcol_q  <= req_cr.col;
                        trow_q  <= req_cr.row;
                        cnt_q   <= '0;
                        state_q <= PRESS;
                    end
                end
                PRESS: begin
                    if (c == tcol_q) begin
                        if (cnt_inc == HOLD_MAX) begin
                            cnt_q   <= '0;
                            state_q <= RELEASE;
                        end else begin
                            cnt_q <= cnt_inc;
                        end
                    end
                end
                RELEASE: begin
                    if (GAP_SCANS == 0) begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                    end else if (c == COL3) begin
                        if (cnt_inc == GAP_LIM) begin
                            cnt_q   <= '0;
                            state_q <= IDLE;
                            done_q  <= 1'b1;
                        end else begin
                            cnt_q <= cnt_inc;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_emulator.sv
// Scoreboard bench for keypad_emulator: stimulus queues expected keys, a monitor checks on done.
module tb_keypad_emulator;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] c = 4'b0000;
    logic [3:0] c_hold = 4'b0000;
    logic       rot_en = 1'b0;

    logic       key_valid = 1'b0;
    logic [3:0] key_code = 4'd0;
    logic [3:0] r;
    logic       key_ready, busy, done;

    logic       key_valid2 = 1'b0;
    logic [3:0] key_code2 = 4'd0;
    logic [3:0] r2;
    logic       key_ready2, busy2, done2;

    int checks = 0;
    int failures = 0;
    int exp_q[$];
    int hold_seen = 0;
    int gap_seen = 0;
    int last_key = -1;
    int mon_e;

    always #5 clk = ~clk;

    keypad_emulator #(.HOLD_SCANS(2), .GAP_SCANS(2), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .c(c), .r(r),
        .key_valid(key_valid), .key_code(key_code), .key_ready(key_ready),
        .busy(busy), .done(done)
    );

    keypad_emulator #(.HOLD_SCANS(2), .GAP_SCANS(0), .CNT_W(8)) dut_g0 (
        .clk(clk), .rst_n(rst_n), .c(c), .r(r2),
        .key_valid(key_valid2), .key_code(key_code2), .key_ready(key_ready2),
        .busy(busy2), .done(done2)
    );

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    function automatic int oh_idx(input logic [3:0] v);
        case (v)
            4'b1000: return 0;
            4'b0100: return 1;
            4'b0010: return 2;
            4'b0001: return 3;
            default: return -1;
        endcase
    endfunction

    // Independent scanner decode: column index x row index -> key
    function automatic int decode(input logic [3:0] cc, input logic [3:0] rr);
        int km[4][4];
        int ci, ri;
        km = '{'{1, 4, 7, 14}, '{2, 5, 8, 0}, '{3, 6, 9, 15}, '{10, 11, 12, 13}};
        ci = oh_idx(cc);
        ri = oh_idx(rr);
        if (ci < 0 || ri < 0) return -1;
        return km[ci][ri];
    endfunction

    // Scanner: advance the column strobe just after each rising edge
    initial forever begin
        @(posedge clk);
        #1;
        if (rot_en) c = $onehot(c) ? {c[0], c[3:1]} : 4'b1000;
        else        c = c_hold;
    end

    // Monitor: every pressed-row sample must match the head key; done retires it
    always @(negedge clk) begin
        if (!rst_n) begin
            hold_seen = 0;
            gap_seen  = 0;
            last_key  = -1;
        end else if (done) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL spurious_done: got done=1 expected no pending key");
            end else begin
                mon_e = exp_q.pop_front();
                chk("key", last_key, mon_e);
                chk("hold_strobes", hold_seen, 2);
                chk("gap_strobes", gap_seen, 2);
            end
            hold_seen = 0;
            gap_seen  = 0;
            last_key  = -1;
        end else if (r != 4'b0000) begin
            chk("r_key", decode(c, r), (exp_q.size() > 0) ? exp_q[0] : -2);
            hold_seen++;
            last_key = decode(c, r);
        end else if (hold_seen >= 2 && c == 4'b0001) begin
            gap_seen++;
        end
    end

    task automatic send(input logic [3:0] k);
        int n;
        n = 0;
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = k;
        while (!key_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!key_ready) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: key %0d never accepted", k);
        end else begin
            exp_q.push_back(int'(k));
        end
        @(posedge clk);
        #1 key_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk(name, exp_q.size(), 0);
        @(negedge clk);
    endtask

    task automatic wait_r(output int ok);
        int n;
        ok = 0;
        n = 0;
        while (n < 100 && ok == 0) begin
            @(negedge clk);
            if (r != 4'b0000) ok = 1;
            n++;
        end
    endtask

    initial begin
        int ok, n, cyc, last, got;

        #12;
        chk("rst_r", r, 0);
        chk("rst_ready", key_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        @(negedge clk);
        rst_n  = 1'b1;
        rot_en = 1'b1;
        @(negedge clk);
        chk("idle_ready", key_ready, 1);

        send(4'd5);
        wait_drain("drain_k5");

        send(4'd14);
        send(4'd13);
        wait_drain("drain_k14_k13");

        // Non-one-hot strobes during PRESS must neither drive rows nor count
        send(4'd6);
        wait_r(ok);
        chk("frz_first_strobe", ok, 1);
        c_hold = 4'b0000;
        rot_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("frz_r_0000", r, 0);
            chk("frz_busy", busy, 1);
        end
        c_hold = 4'b1100;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("frz_r_1100", r, 0);
        end
        rot_en = 1'b1;
        wait_drain("drain_k6");

        // Reset in the middle of a press, with the target column strobed
        send(4'd9);
        wait_r(ok);
        chk("rst_pre_r", r, 4'b0010);
        #2 rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("async_r", r, 0);
        chk("async_busy", busy, 0);
        chk("async_ready", key_ready, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        chk("no_resend_busy", busy, 0);

        // Zero gap, valid held: one RELEASE cycle, then straight back into PRESS
        key_code2  = 4'd5;
        key_valid2 = 1'b1;
        n = 0; cyc = 0; last = -100; got = 0;
        while (n < 200 && got == 0) begin
            @(negedge clk);
            cyc++;
            if (r2 != 4'b0000) last = cyc;
            if (done2) got = 1;
            n++;
        end
        chk("g0_done", got, 1);
        chk("g0_release_len", cyc - last, 2);
        chk("g0_busy_at_done", busy2, 0);
        chk("g0_ready_at_done", key_ready2, 1);
        key_code2 = 4'd10;
        @(negedge clk);
        chk("g0_next_press", busy2, 1);
`ifndef KEYPAD_EMU_QUEUE_EN
        n = 0;
        while (n < 20 && r2 == 4'b0000) begin
            @(negedge clk);
            n++;
        end
        chk("g0_next_key", decode(c, r2), 10);
`endif
        key_valid2 = 1'b0;

`ifdef KEYPAD_EMU_QUEUE_EN
        // One key enters PRESS right away, so the fifth back-to-back push fills the FIFO
        send(4'd1);
        send(4'd2);
        send(4'd3);
        send(4'd10);
        send(4'd4);
        chk("q_full_ready", key_ready, 0);
        wait_drain("q_drain");
`endif

        repeat (5) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
